counter_apb_master: RTL
=======================

# counter_apb_master

Synthesizable APB initiator that turns a simple command/response handshake into APB2-style transfers (no PREADY/PSLVERR) for programming `counter_top` register banks from on-chip sequencer logic. It sits in the `i_pclk` domain and drives the same `paddr/pwdata/pwrite/psel/penable/prdata` bus that `counter_top` responds to. A small command queue decouples the issuer, and a single-entry response register returns read data and write completions in issue order.

## Interface
- `ADDR_W`, 32: APB address width.
- `DATA_W`, 32: APB data width.
- `CMD_DEPTH`, 4: command queue depth. Must be a power of 2 and at least 2.

- `i_pclk`  in  1: the only clock, APB clock.
- `i_prst`  in  1: reset, synchronous, active-high. It is sampled on the rising edge of `i_pclk`.
- `i_cmd_valid`  in  1: command offered.
- `o_cmd_ready`  out  1: queue can accept a command.
- `i_cmd_write`  in  1: 1 = write, 0 = read.
- `i_cmd_addr`  in  ADDR_W: transfer address.
- `i_cmd_wdata`  in  DATA_W: write data, ignored for reads.
- `o_paddr`  out  ADDR_W: APB PADDR.
- `o_pwdata`  out  DATA_W: APB PWDATA.
- `o_pwrite`  out  1: APB PWRITE.
- `o_psel`  out  1: APB PSEL.
- `o_penable`  out  1: APB PENABLE.
- `i_prdata`  in  DATA_W: APB PRDATA.
- `o_rsp_valid`  out  1: response held.
- `i_rsp_ready`  in  1: response consumed.
- `o_rsp_write`  out  1: echo of the command type.
- `o_rsp_rdata`  out  DATA_W: read data; 0 for writes.
- `o_busy`  out  1: asserted when the queue is non-empty, the FSM is not in IDLE, or `o_rsp_valid` is set.

## Operation
- **Command accept.** A command is accepted on `i_cmd_valid & o_cmd_ready`. `o_cmd_ready` equals `!full & !i_prst`, so a push is refused when the queue is full even if a pop happens in the same cycle. Commands are executed strictly in FIFO order.
- **FSM states:** IDLE, SETUP, ACCESS.
- **IDLE → SETUP** requires both conditions below. On that edge the head entry is popped and registered into `o_paddr`, `o_pwdata` and `o_pwrite`.
  - The queue is non-empty.
  - `!o_rsp_valid`, or `i_rsp_ready` is high in the same cycle.
- **SETUP.** `o_psel = 1`, `o_penable = 0`. The FSM always moves to ACCESS on the next edge.
- **ACCESS.** `o_psel = 1`, `o_penable = 1`. The FSM always moves to IDLE on the next edge. On that edge:
  - `o_rsp_valid` is set to 1.
  - `o_rsp_write` is set to `o_pwrite`.
  - `o_rsp_rdata` is set to `i_prdata` for reads, or 0 for writes.
- **Response release.** The response clears on `o_rsp_valid & i_rsp_ready` unless the same edge loads a new response.
- **Idle bus values.** Between transfers `o_psel = o_penable = 0`, while `o_paddr`, `o_pwdata` and `o_pwrite` hold their last values.
- **Reset.** On any `i_prst` edge, in any state:
  - The FSM returns to IDLE.
  - The queue is flushed.
  - A pending response is dropped.
  - Any transfer in flight is abandoned; PSEL falls on that edge.

## Timing
- **Reset values:** every output is 0. `o_cmd_ready` is 0 while `i_prst` is high and becomes 1 in the first cycle after release.
- **Latency:** a command accepted at edge E (with the queue empty and no pending response) puts SETUP on the bus from E+1, ACCESS from E+2, and `o_rsp_valid` from E+3.
- **Throughput:** one transfer per 3 cycles when `i_rsp_ready` is held high. With `i_rsp_ready` low, the bus stalls in IDLE after one completed transfer.
- **Response hold:** the response register is stable while `o_rsp_valid & !i_rsp_ready`.
- **Registered outputs:** all APB outputs are registered, with no combinational path from `i_cmd_*` to the bus. `o_cmd_ready` depends only on the queue count and `i_prst`.

## Structure
- **Shared package `counter_apb_pkg`** holds:
  - the FSM state encoding (IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2);
  - default `ADDR_W`/`DATA_W` constants;
  - the command field packing order {write, addr, wdata}.
- **Sub-module `counter_apb_cmd_fifo`:** synchronous FIFO, `CMD_DEPTH` × (1 + ADDR_W + DATA_W) bits, with full/empty flags derived from a pointer-plus-wrap-bit scheme. The top level contains the FSM and the response register.

## Test plan
- **Reset:** hold `i_prst` for 3 edges with `i_cmd_valid = 1` → all outputs 0 throughout and no command captured; `o_cmd_ready = 1` in the first cycle after release.
- **Single write:** write 0x0000_0004 ← 0x0000_0021, accepted at E → PSEL at E+1 and PENABLE at E+2, with PADDR/PWDATA correct in both cycles; at E+3 the response has `o_rsp_valid = 1`, `o_rsp_write = 1`, `o_rsp_rdata = 0`.
- **Read:** read 0x0000_0010 with `i_prdata` driven to 0xA5A5_0003 in the ACCESS cycle → `o_rsp_rdata = 0xA5A5_0003` and `o_rsp_write = 0`.
- **Backpressure:** push 5 reads with `i_rsp_ready = 0` → the first completes; `o_cmd_ready` falls after 4 entries are queued; no second SETUP occurs until `i_rsp_ready` pulses; then transfers resume in order.
- **Streaming:** 3 writes to 0x0, 0x4, 0x8 with `i_rsp_ready = 1` → SETUP cycles exactly 3 cycles apart, and responses come back in address order.
- **Reset mid-transfer:** assert `i_prst` during ACCESS with 2 commands queued → PSEL and PENABLE are 0 after that edge; no response appears; after release the bus stays idle and `o_busy = 0`.

Source files
------------

// File: rtl/counter_apb_pkg.sv
// Shared definitions for the counter_apb_master APB initiator:
// FSM encoding, default bus widths and the command word layout.
package counter_apb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Queued command word, MSB first: {write, addr, wdata}
    function automatic int cmd_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/counter_apb_cmd_fifo.sv
// Synchronous command FIFO; full/empty come from read/write pointers
// that carry one extra wrap bit beyond the index.
module counter_apb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                     (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
    assign o_rdata = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/counter_apb_master.sv
// APB2 initiator: queued commands become SETUP/ACCESS transfers, and each
// completion is returned through a single-entry response register.
module counter_apb_master
    import counter_apb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CMD_DEPTH = 4
) (
    input  logic              i_pclk,
    input  logic              i_prst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic [ADDR_W-1:0] o_paddr,
    output logic [DATA_W-1:0] o_pwdata,
    output logic              o_pwrite,
    output logic              o_psel,
    output logic              o_penable,
    input  logic [DATA_W-1:0] i_prdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_write,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_busy
);

    localparam int CMD_W = cmd_width(ADDR_W, DATA_W);

    // Handshakes: a beat transfers on the edge where valid & ready are both
    // high; valid holds its payload until then and never waits on ready.
    apb_state_e        r_state;
    apb_state_e        w_state_nxt;
    logic              w_psel_nxt;
    logic              w_penable_nxt;
    logic              r_psel;
    logic              r_penable;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_pwrite;
    logic              r_rsp_valid;
    logic              r_rsp_write;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [CMD_W-1:0]  w_cmd_word;
    logic [CMD_W-1:0]  w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_start;

    assign o_cmd_ready = ~w_full & ~i_prst;
    assign w_push      = i_cmd_valid & o_cmd_ready;
    assign w_cmd_word  = {i_cmd_write, i_cmd_addr, i_cmd_wdata};
    // Launch only when the response slot is free or being drained this edge
    assign w_start     = (r_state == ST_IDLE) & ~w_empty & (~r_rsp_valid | i_rsp_ready);

    counter_apb_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .i_clk   (i_pclk),
        .i_rst   (i_prst),
        .i_push  (w_push),
        .i_wdata (w_cmd_word),
        .i_pop   (w_start),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_pclk) begin
        if (i_prst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus strobes are decoded from the next state so they leave a flop
    always_comb begin
        w_psel_nxt    = (w_state_nxt != ST_IDLE);
        w_penable_nxt = (w_state_nxt == ST_ACCESS);
    end

    always_ff @(posedge i_pclk) begin
        if (i_prst) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
        end else begin
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_prst) begin
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
        end else if (w_start) begin
            r_pwrite <= w_head[CMD_W-1];
            r_paddr  <= w_head[DATA_W +: ADDR_W];
            r_pwdata <= w_head[DATA_W-1:0];
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_prst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
        end else if (r_state == ST_ACCESS) begin
            r_rsp_valid <= 1'b1;
            r_rsp_write <= r_pwrite;
            r_rsp_rdata <= r_pwrite ? '0 : i_prdata;
        end else if (r_rsp_valid && i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign o_paddr     = r_paddr;
    assign o_pwdata    = r_pwdata;
    assign o_pwrite    = r_pwrite;
    assign o_psel      = r_psel;
    assign o_penable   = r_penable;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_write = r_rsp_write;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_busy      = ~w_empty | (r_state != ST_IDLE) | r_rsp_valid;

endmodule
